// File: rtl/alu_seq_exec_if.sv
// Request/response bundle between the issue stage, alu_seq_exec and writeback.
// master = initiator/consumer side, slave = execution unit side.
interface alu_seq_exec_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [2:0]       select;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             overflow;

   modport master (
      output in_valid, a_in, b_in, select, out_ready,
      input  in_ready, out_valid, result, zero, overflow
   );

   modport slave (
      input  in_valid, a_in, b_in, select, out_ready,
      output in_ready, out_valid, result, zero, overflow
   );
endinterface

// File: rtl/alu_seq_exec.sv
// Handshaked execution unit: add/sub/and/or/NOP in one cycle, unsigned
// multiply (shift-add) and unsigned divide (restoring) one bit per cycle.
// One operation in flight; the result is held until writeback takes it.
module alu_seq_exec #(
   parameter int WIDTH = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_seq_exec_if.slave bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      OP_NOP0 = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_MUL  = 3'd3,
      OP_DIV  = 3'd4,
      OP_AND  = 3'd5,
      OP_OR   = 3'd6,
      OP_NOP7 = 3'd7
   } op_t;

   state_t             state, state_n;

   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               ovf_q, ovf_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   // multiply datapath: multiplicand shifts left, multiplier shifts right
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;

   // divide datapath: dividend shifts out MSB first, quotient shifts in
   logic [WIDTH-1:0]   dvd_q, dvd_d;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [WIDTH-1:0]   rem_q, rem_d;

   // single-cycle operation results
   logic [WIDTH-1:0]   sum, diff;
   logic               add_ovf, sub_ovf;

   // one iteration of each multi-cycle algorithm
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH:0]     rem_shift, rem_diff;
   logic               q_bit;
   logic [WIDTH-1:0]   rem_step, dvd_step;
   logic               last_step;

   assign sum     = bus.a_in + bus.b_in;
   assign diff    = bus.a_in - bus.b_in;
   assign add_ovf = (bus.a_in[WIDTH-1] == bus.b_in[WIDTH-1]) && (sum[WIDTH-1] != bus.a_in[WIDTH-1]);
   assign sub_ovf = (bus.a_in[WIDTH-1] != bus.b_in[WIDTH-1]) && (diff[WIDTH-1] != bus.a_in[WIDTH-1]);

   assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
   assign rem_diff  = rem_shift - {1'b0, dvs_q};
   assign q_bit     = ~rem_diff[WIDTH];   // no borrow: divisor fits
   assign rem_step  = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
   assign dvd_step  = {dvd_q[WIDTH-2:0], q_bit};
   assign last_step = (cnt_q == CW'(WIDTH - 1));

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.overflow  = ovf_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of block evaluation order.
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Next-state and datapath next values.
   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // leaves one unassigned would otherwise infer a latch.
      state_n  = state;
      result_d = result_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;

      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               state_n = DONE;
               ovf_d   = 1'b0;
               case (op_t'(bus.select))
                  OP_ADD: begin
                     result_d = sum;
                     ovf_d    = add_ovf;
                  end
                  OP_SUB: begin
                     result_d = diff;
                     ovf_d    = sub_ovf;
                  end
                  OP_AND:  result_d = bus.a_in & bus.b_in;
                  OP_OR:   result_d = bus.a_in | bus.b_in;
                  OP_MUL: begin
                     mcand_d  = {{WIDTH{1'b0}}, bus.a_in};
                     mplier_d = bus.b_in;
                     acc_d    = '0;
                     cnt_d    = '0;
                     state_n  = MUL;
                  end
                  OP_DIV: begin
                     if (bus.b_in == '0) begin
                        result_d = '1;
                        ovf_d    = 1'b1;
                     end else begin
                        dvd_d   = bus.a_in;
                        dvs_d   = bus.b_in;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_n = DIV;
                     end
                  end
                  default: result_d = '0;   // NOP
               endcase
               zero_d = (result_d == '0);
            end
         end

         MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (last_step) begin
               result_d = acc_step[WIDTH-1:0];
               zero_d   = (acc_step[WIDTH-1:0] == '0);
               ovf_d    = |acc_step[2*WIDTH-1:WIDTH];
               state_n  = DONE;
            end
         end

         DIV: begin
            rem_d = rem_step;
            dvd_d = dvd_step;
            cnt_d = cnt_q + CW'(1);
            if (last_step) begin
               result_d = dvd_step;
               zero_d   = (dvd_step == '0);
               ovf_d    = 1'b0;
               state_n  = DONE;
            end
         end

         DONE: begin
            if (bus.out_ready) state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase
   end

   // Datapath and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: datapath registers are reset as well so an aborted operation
      // leaves no stale operands or partial results behind.
      if (!rst_n) begin
         result_q <= '0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
      end
   end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: directed operations with literal expectations plus
// an arithmetic reference model checked against the outputs every cycle.
module tb_alu_seq_exec;

   localparam int W = 64;

   typedef struct packed {
      logic [W-1:0] res;
      logic         zero;
      logic         ovf;
      logic [7:0]   lat;
   } exp_t;

   localparam logic signed [W:0] SMAX = $signed({2'b00, {(W-1){1'b1}}});
   localparam logic signed [W:0] SMIN = $signed({2'b11, {(W-1){1'b0}}});

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   alu_seq_exec_if #(.WIDTH(W)) bus ();

   alu_seq_exec #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Reference: what the unit must return for one request.
   function automatic exp_t model(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t                e;
      logic signed [W:0]   full;
      logic [2*W-1:0]      prod;
      e.res = '0;
      e.ovf = 1'b0;
      e.lat = 8'd1;
      case (sel)
         3'd1: begin
            full  = $signed({a[W-1], a}) + $signed({b[W-1], b});
            e.res = full[W-1:0];
            e.ovf = (full > SMAX) || (full < SMIN);
         end
         3'd2: begin
            full  = $signed({a[W-1], a}) - $signed({b[W-1], b});
            e.res = full[W-1:0];
            e.ovf = (full > SMAX) || (full < SMIN);
         end
         3'd3: begin
            prod  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            e.res = prod[W-1:0];
            e.ovf = (prod >> W) != '0;
            e.lat = 8'(W + 1);
         end
         3'd4: begin
            if (b == '0) begin
               e.res = '1;
               e.ovf = 1'b1;
            end else begin
               e.res = a / b;
               e.lat = 8'(W + 1);
            end
         end
         3'd5:    e.res = a & b;
         3'd6:    e.res = a | b;
         default: e.res = '0;
      endcase
      e.zero = (e.res == '0);
      return e;
   endfunction

   // Model state: one request in flight, cycles elapsed since accept.
   logic busy;
   int   cyc;
   exp_t m_exp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         cyc  <= 0;
      end else if (!busy) begin
         if (bus.in_valid) begin
            busy  <= 1'b1;
            cyc   <= 1;
            m_exp <= model(bus.select, bus.a_in, bus.b_in);
         end
      end else if (cyc >= int'(m_exp.lat) && bus.out_ready) begin
         busy <= 1'b0;
      end else begin
         cyc <= cyc + 1;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         check_bit("rst_out_valid", bus.out_valid, 1'b0);
         check_bit("rst_in_ready", bus.in_ready, 1'b1);
      end else begin
         check_bit("in_ready", bus.in_ready, !busy);
         check_bit("out_valid", bus.out_valid, busy && cyc >= int'(m_exp.lat));
         if (busy && cyc >= int'(m_exp.lat)) begin
            check("result", bus.result, m_exp.res);
            check_bit("zero", bus.zero, m_exp.zero);
            check_bit("overflow", bus.overflow, m_exp.ovf);
         end
      end
   end

   // Present a request and hold it until accepted; returns #1 after the accept edge.
   task automatic issue(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.select   = sel;
      bus.a_in     = a;
      bus.b_in     = b;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) check_bit("accept_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   // Wait for the response; hold < 0 keeps out_ready high throughout,
   // otherwise out_ready is withheld for 'hold' cycles once valid.
   task automatic wait_resp(input int hold, output logic [W-1:0] res, output logic z,
                            output logic ov, output int lat);
      lat = 1;
      if (hold < 0) bus.out_ready = 1'b1;
      @(negedge clk);
      while (!bus.out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.out_valid) check_bit("resp_timeout", 1'b0, 1'b1);
      res = bus.result;
      z   = bus.zero;
      ov  = bus.overflow;
      repeat (hold > 0 ? hold : 0) @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask

   task automatic do_op(input string name, input logic [2:0] sel, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold, input logic [W-1:0] e_res,
                        input logic e_z, input logic e_ov, input int e_lat);
      logic [W-1:0] res;
      logic         z, ov;
      int           lat;
      issue(sel, a, b);
      wait_resp(hold, res, z, ov, lat);
      check({name, "_res"}, res, e_res);
      check_bit({name, "_zero"}, z, e_z);
      check_bit({name, "_ovf"}, ov, e_ov);
      check({name, "_lat"}, W'(lat), W'(e_lat));
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.select    = 3'd0;
      bus.a_in      = '0;
      bus.b_in      = '0;

      repeat (3) @(negedge clk);
      check("reset_result", bus.result, '0);
      check_bit("reset_zero", bus.zero, 1'b0);
      check_bit("reset_ovf", bus.overflow, 1'b0);
      #2 rst_n = 1'b1;

      // single-cycle ops
      do_op("add",      3'd1, 64'd5, 64'd10, 0, 64'd15, 1'b0, 1'b0, 1);
      do_op("sub",      3'd2, 64'd15, 64'd7, 0, 64'd8, 1'b0, 1'b0, 1);
      do_op("add_ovf",  3'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0,
            64'h8000_0000_0000_0000, 1'b0, 1'b1, 1);
      do_op("sub_zero", 3'd2, 64'd9, 64'd9, -1, 64'd0, 1'b1, 1'b0, 1);
      do_op("sub_wrap", 3'd2, 64'd0, 64'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1);
      do_op("sub_ovf",  3'd2, 64'h8000_0000_0000_0000, 64'd1, 0,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1);
      do_op("and",      3'd5, 64'd15, 64'd7, 0, 64'd7, 1'b0, 1'b0, 1);
      do_op("or",       3'd6, 64'd12, 64'd5, 0, 64'd13, 1'b0, 1'b0, 1);
      do_op("nop0",     3'd0, 64'd12, 64'd5, 0, 64'd0, 1'b1, 1'b0, 1);
      do_op("nop7",     3'd7, 64'hFF, 64'hFF, 0, 64'd0, 1'b1, 1'b0, 1);

      // multiply
      do_op("mul",      3'd3, 64'd8, 64'd3, 0, 64'd24, 1'b0, 1'b0, 65);
      do_op("mul_big",  3'd3, 64'h1_0000_0000, 64'h1_0000_0000, 0, 64'd0, 1'b1, 1'b1, 65);
      do_op("mul_ones", 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, -1,
            64'd1, 1'b0, 1'b1, 65);

      // divide
      do_op("div",      3'd4, 64'd25, 64'd5, 0, 64'd5, 1'b0, 1'b0, 65);
      do_op("div_rnd",  3'd4, 64'd7, 64'd2, -1, 64'd3, 1'b0, 1'b0, 65);
      do_op("div_big",  3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 0,
            64'h5555_5555_5555_5555, 1'b0, 1'b0, 65);
      do_op("div_small",3'd4, 64'd3, 64'd7, 0, 64'd0, 1'b1, 1'b0, 65);
      do_op("div0",     3'd4, 64'd100, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1);

      // backpressure: the per-cycle compare checks stability while held
      do_op("bp_and",   3'd5, 64'hF0F0, 64'hFF00, 10, 64'hF000, 1'b0, 1'b0, 1);
      @(negedge clk);
      check_bit("bp_ready_after", bus.in_ready, 1'b1);

      // reset in the middle of a multiply
      issue(3'd3, 64'd1234, 64'd5678);
      repeat (20) @(negedge clk);
      check_bit("mid_busy", bus.in_ready, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_bit("abort_valid", bus.out_valid, 1'b0);
      check_bit("abort_ready", bus.in_ready, 1'b1);
      check("abort_result", bus.result, '0);
      check_bit("abort_zero", bus.zero, 1'b0);
      check_bit("abort_ovf", bus.overflow, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      #1 check_bit("release_ready", bus.in_ready, 1'b1);
      repeat (70) @(negedge clk);   // no stray response may appear
      do_op("add_after", 3'd1, 64'd1, 64'd1, 0, 64'd2, 1'b0, 1'b0, 1);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
